// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port MIPS register file with write-to-read bypass,
// a per-register pending scoreboard and a post-reset clearing sweep.
//
// Access handshake: o_ready is the single "accepting" indication for the
// whole block. While o_ready is 0 (INIT sweep), every strobe (i_wr_en,
// i_rsv_en, i_flush) is ignored and all read outputs are forced to zero.
// While o_ready is 1 (RUN), a strobe held high at a rising edge is consumed
// at that edge; there is no back-pressure once the sweep has finished.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD*ADDR_W-1:0]   i_rd_addr,
  output logic [NRD*DATA_W-1:0]   o_rd_data,
  output logic [NRD-1:0]          o_rd_busy,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_rsv_en,
  input  logic [ADDR_W-1:0]       i_rsv_addr,
  input  logic                    i_flush,
  output logic                    o_ready,
  output logic [ADDR_W:0]         o_pend_cnt,
  output logic                    o_dbg_state   // 0 = INIT sweep, 1 = RUN
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_init_idx;
  logic                r_ready;
  logic [NREG-1:0]     r_pend;
  logic [DATA_W-1:0]   r_regs [NREG];

  logic                w_run;
  logic                w_wr_go;
  logic                w_rsv_go;
  logic [NREG-1:0]     w_pend_nxt;
  logic [ADDR_W:0]     w_pend_cnt;

  assign w_run    = (r_state == ST_RUN);
  // Register 0 is hardwired, so strobes aimed at it never take effect.
  assign w_wr_go  = w_run && i_wr_en  && (i_wr_addr  != '0);
  assign w_rsv_go = w_run && i_rsv_en && (i_rsv_addr != '0);

  // Next pending vector: flush, then writeback clear, then reserve (reserve wins).
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_flush) begin
      w_pend_nxt = '0;
    end
    if (w_wr_go) begin
      w_pend_nxt[i_wr_addr] = 1'b0;
    end
    if (w_rsv_go) begin
      w_pend_nxt[i_rsv_addr] = 1'b1;
    end
  end

  // Sequencer: INIT sweep over indices 1..NREG-1, then RUN with scoreboard updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= ADDR_W'(1);
      r_ready    <= 1'b0;
      r_pend     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + ADDR_W'(1);
          if (r_init_idx == LAST_IDX) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_pend <= w_pend_nxt;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Storage array: cleared only by the sweep, never by the asynchronous reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_regs[r_init_idx] <= '0;
    end else if (w_wr_go) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Pending count: popcount of the registered scoreboard.
  always_comb begin
    w_pend_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_pend_cnt = w_pend_cnt + (ADDR_W + 1)'(r_pend[i]);
    end
  end

  assign o_pend_cnt  = w_run ? w_pend_cnt : '0;
  assign o_ready     = r_ready;
  assign o_dbg_state = w_run;

  // Read ports are fully independent copies of the same lookup.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
    // A same-cycle writeback to this address both forwards its data and
    // retires the reservation as seen by this port.
    assign w_hit  = i_wr_en && (i_wr_addr == w_addr);

    // Per-port read mux: zero for r0 / INIT, bypass on write hit, else array.
    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_run && (w_addr != '0)) begin
        w_data = w_hit ? i_wr_data : r_regs[w_addr];
        w_busy = r_pend[w_addr] && !w_hit;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
    assign o_rd_busy[k]                  = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with a behavioural model that
// is compared against every output on every falling clock edge.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NREG   = 2 ** ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*ADDR_W-1:0] rd_addr = '0;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en = 1'b0;
  logic [ADDR_W-1:0]     wr_addr = '0;
  logic [DATA_W-1:0]     wr_data = '0;
  logic                  rsv_en = 1'b0;
  logic [ADDR_W-1:0]     rsv_addr = '0;
  logic                  flush = 1'b0;
  logic                  ready;
  logic [ADDR_W:0]       pend_cnt;
  logic                  dbg_state;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_flush    (flush),
    .o_ready    (ready),
    .o_pend_cnt (pend_cnt),
    .o_dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: array contents, set of pending registers, edges since reset.
  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_pend [NREG];
  bit                m_ready;
  int                m_edges;

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_ready = 1'b0;
    m_edges = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_ready = 1'b0;
        m_edges = 0;
      end else if (!m_ready) begin
        // The k-th edge after release clears register k.
        m_edges++;
        m_regs[m_edges] = '0;
        if (m_edges == NREG - 1) m_ready = 1'b1;
      end else begin
        if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        if (wr_en && wr_addr != 0) begin
          m_regs[wr_addr] = wr_data;
          m_pend[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      end
    end
  end

  function automatic int model_pend_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready", 64'(ready), 64'(m_ready));
        check("pend_cnt", 64'(pend_cnt), 64'(m_ready ? model_pend_cnt() : 0));
        for (int k = 0; k < NRD; k++) begin
          logic [ADDR_W-1:0] a;
          logic [DATA_W-1:0] ed;
          bit                eb;
          a  = rd_addr[k*ADDR_W +: ADDR_W];
          ed = '0;
          eb = 1'b0;
          if (m_ready && a != 0) begin
            ed = (wr_en && wr_addr == a) ? wr_data : m_regs[a];
            eb = m_pend[a] && !(wr_en && wr_addr == a);
          end
          check($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(ed));
          check($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(eb));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    // Reset release with a write held on r3 the whole time.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA;
    set_rd(3, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_pend_cnt", 64'(pend_cnt), 64'd0);
    check("reset_dbg_state", 64'(dbg_state), 64'd0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check($sformatf("init_ready_edge%0d", i), 64'(ready), 64'd0);
      check("init_rd_data", 64'(port_data(0)), 64'd0);
    end
    tick();
    check("ready_after_31", 64'(ready), 64'd1);
    check("run_dbg_state", 64'(dbg_state), 64'd1);
    idle();
    #1;
    check("r3_after_init", 64'(port_data(0)), 64'd0);
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(r, r + 1);
      #1;
      check("sweep_zero_p0", 64'(port_data(0)), 64'd0);
      check("sweep_zero_p1", 64'(port_data(1)), 64'd0);
    end

    // Write with same-cycle bypass on both ports.
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    set_rd(7, 7);
    #1;
    check("bypass_p0", 64'(port_data(0)), 64'hDEADBEEF);
    check("bypass_p1", 64'(port_data(1)), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    check("stored_p0", 64'(port_data(0)), 64'hDEADBEEF);
    check("stored_p1", 64'(port_data(1)), 64'hDEADBEEF);

    // r0 protection.
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_rd(0, 0);
    #1;
    check("r0_same_cycle", 64'(port_data(0)), 64'd0);
    tick();
    idle();
    #1;
    check("r0_data", 64'(port_data(0)), 64'd0);
    check("r0_busy", 64'(rd_busy[0]), 64'd0);
    check("r0_pend_cnt", 64'(pend_cnt), 64'd0);

    // Scoreboard reserve / writeback / flush.
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    rsv_addr = 5'd9;
    tick();
    idle();
    set_rd(5, 9);
    #1;
    check("sb_pend_cnt2", 64'(pend_cnt), 64'd2);
    check("sb_r5_busy", 64'(rd_busy[0]), 64'd1);
    check("sb_r9_busy", 64'(rd_busy[1]), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    #1;
    check("sb_wb_busy", 64'(rd_busy[0]), 64'd0);
    check("sb_wb_data", 64'(port_data(0)), 64'h55);
    tick();
    idle();
    #1;
    check("sb_pend_cnt1", 64'(pend_cnt), 64'd1);
    flush = 1'b1;
    tick();
    idle();
    #1;
    check("sb_flush_cnt", 64'(pend_cnt), 64'd0);

    // Collision: reserve + write on r4 plus flush, with r6 pending.
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    flush = 1'b1;
    tick();
    idle();
    set_rd(4, 6);
    #1;
    check("col_r4_busy", 64'(rd_busy[0]), 64'd1);
    check("col_r4_data", 64'(port_data(0)), 64'h44);
    check("col_r6_busy", 64'(rd_busy[1]), 64'd0);
    check("col_pend_cnt", 64'(pend_cnt), 64'd1);

    // Re-reserving a pending register needs only one writeback.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444;
    tick();
    idle();
    #1;
    check("rersv_busy", 64'(rd_busy[0]), 64'd0);
    check("rersv_cnt", 64'(pend_cnt), 64'd0);

    // A small table of writes across the array, read back on both ports.
    for (int i = 1; i < NREG; i += 5) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 32'h1000_0000 + DATA_W'(i * 32'h0101);
      set_rd(i, (i + 7) % NREG);
      tick();
    end
    idle();
    for (int i = 1; i < NREG; i += 5) begin
      set_rd(i, NREG - i);
      #1;
      check("table_rd", 64'(port_data(0)), 64'(32'h1000_0000 + DATA_W'(i * 32'h0101)));
    end

    // Mid-operation asynchronous reset.
    tick();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd2;
    tick();
    idle();
    set_rd(2, 2);
    #1;
    check("mid_pre_data", 64'(port_data(0)), 64'h22);
    check("mid_pre_busy", 64'(rd_busy[0]), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ready_drop", 64'(ready), 64'd0);
    check("mid_pend_cnt", 64'(pend_cnt), 64'd0);
    check("mid_busy", 64'(rd_busy[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) tick();
    check("mid_ready_30", 64'(ready), 64'd0);
    tick();
    check("mid_ready_31", 64'(ready), 64'd1);
    check("mid_r2_data", 64'(port_data(0)), 64'd0);
    check("mid_r2_busy", 64'(rd_busy[0]), 64'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
